// File: rtl/taadda_pkg.sv
// taadda_pkg: shared opcode layout, function enums, select helpers.
// Imported by the ALU, the core and the port interface users.
package taadda_pkg;

   localparam int OP_IMM1 = 7;
   localparam int OP_IMM2 = 6;
   localparam int OP_BR   = 5;
   localparam int OP_HALT = 4;
   localparam int FN_W    = 3;

   typedef enum logic [FN_W-1:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOT,
      ALU_SHL,
      ALU_SHR
   } alu_fn_e;

   typedef enum logic [FN_W-1:0] {
      BR_EQ,
      BR_NE,
      BR_LT,
      BR_LE,
      BR_GT,
      BR_GE,
      BR_ALWAYS,
      BR_NEVER
   } br_fn_e;

   typedef enum logic {
      ST_RUN,
      ST_HALT
   } state_e;

   function automatic int sel_in(input int num_regs);
      return num_regs;
   endfunction

   function automatic int sel_pc(input int num_regs);
      return num_regs + 1;
   endfunction

endpackage

// File: rtl/taadda_if.sv
// taadda_if: program-store fetch bus plus valid/ready I/O ports.
// master = core side, slave = store / I/O fabric side.
interface taadda_if #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8
);
   logic [PC_W-1:0]     instr_addr;
   logic [4*DATA_W-1:0] instr_data;
   logic [DATA_W-1:0]   in_data;
   logic                in_valid;
   logic                in_ready;
   logic [DATA_W-1:0]   out_data;
   logic                out_valid;
   logic                out_ready;
   logic                halted;

   modport master (
      output instr_addr,
      input  instr_data,
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data,
      output out_valid,
      input  out_ready,
      output halted
   );

   modport slave (
      input  instr_addr,
      output instr_data,
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data,
      input  out_valid,
      output out_ready,
      input  halted
   );
endinterface

// File: rtl/taadda_alu.sv
// taadda_alu: combinational ALU result and branch condition.
// TAADDA_SIGNED_CMP_EN selects two's-complement ordered compares.
module taadda_alu
   import taadda_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [FN_W-1:0]   fn_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] res_o,
   output logic              taken_o
);

   localparam logic [DATA_W-1:0] WIDTH = DATA_W'(DATA_W);

   logic [DATA_W-1:0] shamt;
   logic              eq;
   logic              lt;

   assign shamt = b_i % WIDTH;
   assign eq    = (a_i == b_i);

`ifdef TAADDA_SIGNED_CMP_EN
   assign lt = ($signed(a_i) < $signed(b_i));
`else
   assign lt = (a_i < b_i);
`endif

   // Arithmetic/logic result, wrapping at DATA_W bits
   always_comb begin
      res_o = '0;
      unique case (alu_fn_e'(fn_i))
         ALU_ADD: res_o = a_i + b_i;
         ALU_SUB: res_o = a_i - b_i;
         ALU_AND: res_o = a_i & b_i;
         ALU_OR:  res_o = a_i | b_i;
         ALU_XOR: res_o = a_i ^ b_i;
         ALU_NOT: res_o = ~a_i;
         ALU_SHL: res_o = a_i << shamt;
         ALU_SHR: res_o = a_i >> shamt;
      endcase
   end

   // Branch condition of arg1 against arg2
   always_comb begin
      taken_o = 1'b0;
      unique case (br_fn_e'(fn_i))
         BR_EQ:     taken_o = eq;
         BR_NE:     taken_o = !eq;
         BR_LT:     taken_o = lt;
         BR_LE:     taken_o = lt | eq;
         BR_GT:     taken_o = !(lt | eq);
         BR_GE:     taken_o = !lt;
         BR_ALWAYS: taken_o = 1'b1;
         BR_NEVER:  taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/taadda_core.sv
// taadda_core: 4-field instruction core, register file, PC, RUN/HALT.
// Compare signedness set by TAADDA_SIGNED_CMP_EN (see taadda_alu).
module taadda_core
   import taadda_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 6,
   parameter int PC_W     = 8
) (
   input  logic     clk,
   input  logic     rst,
   taadda_if.master bus
);

   localparam logic [DATA_W-1:0] SEL_IN = DATA_W'(sel_in(NUM_REGS));
   localparam logic [DATA_W-1:0] SEL_PC = DATA_W'(sel_pc(NUM_REGS));

   state_e            state_q;
   state_e            state_d;
   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   pc_d;
   logic [DATA_W-1:0] regs_q [NUM_REGS];

   logic [DATA_W-1:0] op;
   logic [DATA_W-1:0] a1f;
   logic [DATA_W-1:0] a2f;
   logic [DATA_W-1:0] dst;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;
   logic [DATA_W-1:0] pc_ext;
   logic [DATA_W-1:0] alu_res;
   logic              taken;
   logic              is_halt;
   logic              is_br;
   logic              is_alu;
   logic              rd_in;
   logic              wr_out;
   logic              wr_pc;
   logic              in_rdy;
   logic              out_vld;
   logic              commit;
   logic              unused_op;

   assign op  = bus.instr_data[DATA_W-1:0];
   assign a1f = bus.instr_data[2*DATA_W-1:DATA_W];
   assign a2f = bus.instr_data[3*DATA_W-1:2*DATA_W];
   assign dst = bus.instr_data[4*DATA_W-1:3*DATA_W];

   assign unused_op = op[3];

   assign is_halt = op[OP_HALT];
   assign is_br   = !is_halt && op[OP_BR];
   assign is_alu  = !is_halt && !op[OP_BR];

   // Both operands on the input port still consume one word
   assign rd_in = !is_halt &&
                  ((!op[OP_IMM1] && a1f == SEL_IN) ||
                   (!op[OP_IMM2] && a2f == SEL_IN));
   assign wr_out = is_alu && (dst == SEL_IN);
   assign wr_pc  = is_alu && (dst == SEL_PC);

   assign pc_ext = DATA_W'(pc_q);

   // Operand fetch: immediate, register, input port, PC, else zero
   always_comb begin
      opa = '0;
      opb = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (a1f == DATA_W'(i)) opa = regs_q[i];
         if (a2f == DATA_W'(i)) opb = regs_q[i];
      end
      if (a1f == SEL_IN) opa = bus.in_data;
      if (a2f == SEL_IN) opb = bus.in_data;
      if (a1f == SEL_PC) opa = pc_ext;
      if (a2f == SEL_PC) opb = pc_ext;
      if (op[OP_IMM1])   opa = a1f;
      if (op[OP_IMM2])   opb = a2f;
   end

   taadda_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .fn_i    (op[FN_W-1:0]),
      .a_i     (opa),
      .b_i     (opb),
      .res_o   (alu_res),
      .taken_o (taken)
   );

   // Handshakes, commit and RUN->HALT; reset holds all transfers off
   always_comb begin
      state_d = state_q;
      in_rdy  = 1'b0;
      out_vld = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (!rst) begin
               in_rdy  = rd_in && (!wr_out || bus.out_ready);
               out_vld = wr_out && (!rd_in || bus.in_valid);
               commit  = (!rd_in || bus.in_valid) &&
                         (!wr_out || bus.out_ready);
               if (commit && is_halt) state_d = ST_HALT;
            end
         end
         ST_HALT: state_d = ST_HALT;
      endcase
   end

   // Next PC: taken branch, ALU write to PC, else sequential
   always_comb begin
      pc_d = pc_q + PC_W'(1);
      if (is_br && taken) pc_d = PC_W'(dst);
      else if (wr_pc)     pc_d = PC_W'(alu_res);
   end

   // RUN/HALT state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_RUN;
      else     state_q <= state_d;
   end

   // PC and register file update only on commit
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (commit) begin
         pc_q <= pc_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (is_alu && dst == DATA_W'(i)) regs_q[i] <= alu_res;
         end
      end
   end

   assign bus.instr_addr = pc_q;
   assign bus.in_ready   = in_rdy;
   assign bus.out_valid  = out_vld;
   assign bus.out_data   = out_vld ? alu_res : '0;
   assign bus.halted     = (state_q == ST_HALT);

endmodule
